crc_stream_checker: RTL and testbench
=====================================

Name: crc_stream_checker

Overview:
- Receive-side counterpart of the serial LFSR CRC generator.
- Consumes a bit-serial frame (data bits followed by the transmitted CRC, MSB first), recomputes the CRC with a runtime-programmable polynomial, and reports pass/fail at end of frame.
- Sits between the serial bit deserialiser and the status/IO logic of the CRC design.

Parameters:
- WIDTH, 64, physical LFSR width; maximum supported CRC length.
- CNT_W, 16, width of the data-bit counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin new frame: load init_value, enter DATA.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data/CRC bit, MSB first.
- last_data  input  1  qualifies bit_valid: this is the final data bit.
- taps  input  WIDTH  polynomial without the implicit x^N term, bit0 = x^0.
- init_value  input  WIDTH  LFSR seed.
- crc_bits  input  7  active CRC length N, legal range 1..WIDTH.
- residue  input  WIDTH  expected remainder after the CRC is shifted in (0 for CRCs without final XOR).
- busy  output  1  high in DATA or CRC state.
- done  output  1  one-cycle pulse when the result is valid.
- crc_ok  output  1  frame passed; held until next start.
- crc_err  output  1  frame failed; held until next start.
- abort  output  1  one-cycle pulse when start arrives mid-frame.
- data_count  output  CNT_W  data bits accepted in the current or last frame (saturating).
- value  output  WIDTH  current LFSR contents, masked to N bits.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; lfsr = 0; counters = 0.
  - busy, done, crc_ok, crc_err and abort are 0; data_count = 0.
- N is sampled at start and latched for the frame. crc_bits of 0 or greater than WIDTH is treated as WIDTH. mask = (1<<N)-1.
- Shift step (Galois, MSB first), applied on each accepted bit:
  - fb = lfsr[N-1] ^ bit_in
  - lfsr_next = ((lfsr << 1) & mask) ^ (fb ? (taps & mask) : 0)
- taps, init_value and residue are used combinationally and must be stable for the whole frame.
- IDLE:
  - start: lfsr <= init_value & mask; clear crc_ok, crc_err, data_count; go to DATA.
  - bit_valid is ignored.
- DATA:
  - Each bit_valid performs a shift step and increments data_count (saturates at all-ones).
  - bit_valid with last_data: go to CRC with crc_cnt = 0.
- CRC:
  - Each bit_valid performs a shift step; last_data is ignored; crc_cnt increments.
  - On the accept with crc_cnt == N-1, go to DONE. The result compares the post-shift lfsr value.
- DONE (one cycle):
  - done = 1.
  - If (lfsr & mask) == (residue & mask), crc_ok <= 1, else crc_err <= 1.
  - Next state is IDLE. bit_valid in DONE is ignored.
  - Latency: done is asserted the cycle after the final CRC bit is accepted.
- start in any state other than IDLE:
  - Reloads the LFSR and restarts in DATA.
  - If the state was DATA or CRC, abort pulses for one cycle.
  - start in DONE still completes that frame's result: done, crc_ok and crc_err update that cycle, then the new frame begins.
- start together with bit_valid in the same cycle: start wins and the bit is dropped.
- Bubbles (bit_valid low) are allowed anywhere in a frame; state is held.
- value is always lfsr & mask.
- crc_ok and crc_err are never both 1.

Decomposition:
- Package crc_pkg holds:
  - state enum {IDLE, DATA, CRC, DONE};
  - localparam CRC_BITS_W = 7;
  - a function galois_step(lfsr, bit, taps, mask).
- Sub-module crc_lfsr_core (masked Galois register with load/shift) is natural; it is shared with the generator side.

Test Plan:
- CRC-8: taps 0x07, init 0, N=8, residue 0. Feed "123456789" (72 bits) then 0xF4 -> done 1 cycle after the last bit, crc_ok=1, value=0.
- Same frame with bit 13 flipped -> crc_err=1, crc_ok=0, value≠0.
- CRC-16/XMODEM: taps 0x1021, init 0, N=16. "123456789" + 0x31C3 with random bit_valid bubbles -> crc_ok=1, data_count=72.
- CRC-32/MPEG-2: taps 0x04C11DB7, init 0xFFFFFFFF, N=32. "123456789" + 0x0376E6E7 -> crc_ok=1. Repeat with crc_bits=0 and taps/init zero-extended to 64 -> masks to N=64 without X; compute the expected result from a reference model.
- Abort: start while 20 bits into DATA -> abort pulse, data_count=0, new CRC-8 frame passes. start coincident with bit_valid -> bit dropped (data_count unchanged).
- Async reset asserted mid-CRC state -> all outputs 0 immediately without a clock edge. After release, a full valid frame passes.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and helpers for the serial CRC generator/checker pair.
package crc_pkg;

  // Widest LFSR the helpers support; narrower instances zero-extend into it.
  localparam int unsigned MAX_W      = 64;
  localparam int unsigned CRC_BITS_W = 7;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC,
    DONE
  } state_t;

  // Low-order mask of n ones; n at or beyond MAX_W yields all ones.
  function automatic word_t crc_mask(input logic [CRC_BITS_W-1:0] n);
    word_t m;
    if (n >= CRC_BITS_W'(MAX_W)) begin
      m = '1;
    end else begin
      m = (word_t'(1) << n) - word_t'(1);
    end
    return m;
  endfunction

  // One MSB-first Galois step. The feedback tap position N-1 is the single
  // bit of mask that is not also set in mask >> 1, so N is not needed here.
  function automatic word_t galois_step(input word_t lfsr, input logic bit_in,
                                        input word_t taps, input word_t mask);
    word_t top;
    logic  fb;
    top = mask & ~(mask >> 1);
    fb  = (|(lfsr & top)) ^ bit_in;
    return ((lfsr << 1) & mask) ^ (fb ? (taps & mask) : '0);
  endfunction

endpackage

// File: rtl/crc_lfsr_core.sv
// Masked Galois LFSR register with load and shift, shared by generator and checker.
module crc_lfsr_core
  import crc_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_value,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] lfsr;
  word_t            stepped;

  // Next LFSR contents for an accepted bit.
  always_comb begin
    stepped = galois_step(word_t'(lfsr), bit_in, word_t'(taps), word_t'(mask));
  end

  // Load has priority over shift so a new frame always starts from the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= load_value;
    end else if (shift) begin
      lfsr <= stepped[WIDTH-1:0];
    end
  end

  assign value = lfsr & mask;

endmodule

// File: rtl/crc_stream_checker.sv
// Receive-side serial CRC checker: recomputes the CRC over data+CRC bits
// and flags pass/fail against the expected residue at end of frame.
module crc_stream_checker
  import crc_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  last_data,
  input  logic [WIDTH-1:0]      taps,
  input  logic [WIDTH-1:0]      init_value,
  input  logic [CRC_BITS_W-1:0] crc_bits,
  input  logic [WIDTH-1:0]      residue,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_ok,
  output logic                  crc_err,
  output logic                  abort,
  output logic [CNT_W-1:0]      data_count,
  output logic [WIDTH-1:0]      value
);

  localparam logic [CRC_BITS_W-1:0] FULL_N = CRC_BITS_W'(WIDTH);

  state_t                state, state_next;
  logic [CRC_BITS_W-1:0] n_q, n_start, crc_cnt;
  word_t                 mask_w, mask_start_w;
  logic [WIDTH-1:0]      mask, mask_start, load_value;
  logic                  in_frame, accept, last_crc, match;
  logic [CNT_W-1:0]      count_q;
  logic                  ok_q, err_q, abort_q;

  // Frame length sanitising and the masks for the latched and incoming N.
  always_comb begin
    n_start      = ((crc_bits == '0) || (crc_bits > FULL_N)) ? FULL_N : crc_bits;
    mask_w       = crc_mask(n_q);
    mask_start_w = crc_mask(n_start);
    mask         = mask_w[WIDTH-1:0];
    mask_start   = mask_start_w[WIDTH-1:0];
    load_value   = init_value & mask_start;
  end

  // Bit acceptance and end-of-frame conditions; start always wins over a bit.
  always_comb begin
    in_frame = (state == DATA) || (state == CRC);
    accept   = bit_valid && !start && in_frame;
    last_crc = (state == CRC) && (crc_cnt == (n_q - CRC_BITS_W'(1)));
    match    = (value == (residue & mask));
  end

  crc_lfsr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start),
    .shift     (accept),
    .load_value(load_value),
    .bit_in    (bit_in),
    .taps      (taps),
    .mask      (mask),
    .value     (value)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start from any state restarts the frame in DATA.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = DATA;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        DATA:    if (accept && last_data) state_next = CRC;
        CRC:     if (accept && last_crc) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame length latch and CRC-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= FULL_N;
      crc_cnt <= '0;
    end else begin
      if (start) begin
        n_q <= n_start;
      end
      if ((state == DATA) && accept && last_data) begin
        crc_cnt <= '0;
      end else if ((state == CRC) && accept) begin
        crc_cnt <= crc_cnt + CRC_BITS_W'(1);
      end
    end
  end

  // Saturating count of accepted data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if ((state == DATA) && accept && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Result flags and abort pulse. A start landing in DONE still records the
  // finishing frame's verdict instead of clearing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= start && in_frame;
      if (state == DONE) begin
        ok_q  <= match;
        err_q <= !match;
      end else if (start) begin
        ok_q  <= 1'b0;
        err_q <= 1'b0;
      end
    end
  end

  assign busy       = in_frame;
  assign done       = (state == DONE);
  assign crc_ok     = ok_q;
  assign crc_err    = err_q;
  assign abort      = abort_q;
  assign data_count = count_q;

endmodule

// File: tb/tb_crc_stream_checker.sv
// Directed bench for crc_stream_checker with a frame-result scoreboard.
module tb_crc_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, bit_valid, bit_in, last_data;
  logic [63:0] taps, init_value, residue;
  logic [6:0]  crc_bits;
  logic        busy, done, crc_ok, crc_err, abort;
  logic [15:0] data_count;
  logic [63:0] value;

  typedef struct {
    logic        ok;
    logic [63:0] value;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  bit          fbits[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  string       msg   = "123456789";
  logic [63:0] c64;

  crc_stream_checker #(
    .WIDTH(64),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .last_data (last_data),
    .taps      (taps),
    .init_value(init_value),
    .crc_bits  (crc_bits),
    .residue   (residue),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .abort     (abort),
    .data_count(data_count),
    .value     (value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_mask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Bit-by-bit reference: feedback taken from bit n-1 of the register.
  function automatic logic [63:0] model_run(input logic [63:0] tp, input logic [63:0] ini,
                                            input int n, input int nbits);
    logic [63:0] m;
    logic [63:0] r;
    logic        fb;
    m = mk_mask(n);
    r = ini & m;
    for (int i = 0; i < nbits; i++) begin
      fb = r[n-1] ^ fbits[i];
      r  = (r << 1) & m;
      if (fb) r = r ^ (tp & m);
    end
    return r;
  endfunction

  task automatic build(input logic [63:0] crc, input int n, input int flip);
    logic [7:0] ch;
    fbits.delete();
    for (int c = 0; c < 9; c++) begin
      ch = msg[c];
      for (int b = 7; b >= 0; b--) fbits.push_back(ch[b]);
    end
    for (int b = n - 1; b >= 0; b--) fbits.push_back(crc[b]);
    if (flip >= 0) fbits[flip] = !fbits[flip];
  endtask

  task automatic send_bits(input int from, input int to, input bit bubbles);
    for (int i = from; i < to; i++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) tick;
      bit_valid = 1'b1;
      bit_in    = fbits[i];
      last_data = (i == 71);
      tick;
      bit_valid = 1'b0;
      last_data = 1'b0;
    end
  endtask

  task automatic do_start(input bit with_bit);
    start = 1'b1;
    if (with_bit) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
    end
    tick;
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic set_crc8;
    taps = 64'h07; init_value = '0; residue = '0; crc_bits = 7'd8;
  endtask

  task automatic run_frame(input string name, input logic [63:0] tp, input logic [63:0] ini,
                           input logic [63:0] res, input logic [6:0] cb, input int n,
                           input bit bubbles, input bit exp_abort, input bit with_bit);
    exp_t e;
    exp_t got;
    int   w;
    taps = tp; init_value = ini; residue = res; crc_bits = cb;
    do_start(with_bit);
    check({name, ":abort"}, abort, exp_abort);
    check({name, ":start_count"}, data_count, 0);
    check({name, ":start_value"}, value, ini & mk_mask(n));
    check({name, ":busy"}, busy, 1);
    e.value = model_run(tp, ini, n, fbits.size());
    e.ok    = (e.value == (res & mk_mask(n)));
    e.count = 16'd72;
    sb.push_back(e);
    send_bits(0, fbits.size(), bubbles);
    w = 0;
    while (done !== 1'b1 && w < 8) begin
      tick;
      w++;
    end
    check({name, ":done_latency"}, w, 0);
    check({name, ":done"}, done, 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({name, ":value"}, value, got.value);
      check({name, ":count"}, data_count, got.count);
      tick;
      check({name, ":done_pulse"}, done, 0);
      check({name, ":idle"}, busy, 0);
      check({name, ":ok"}, crc_ok, got.ok);
      check({name, ":err"}, crc_err, !got.ok);
      tick;
      check({name, ":ok_held"}, crc_ok, got.ok);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; last_data = 1'b0;
    set_crc8;
    #12;
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:ok", crc_ok, 0);
    check("rst:err", crc_err, 0);
    check("rst:abort", abort, 0);
    check("rst:count", data_count, 0);
    check("rst:value", value, 0);
    rst_n = 1'b1;
    tick;

    build(64'hF4, 8, -1);
    run_frame("crc8", 64'h07, 64'h0, 64'h0, 7'd8, 8, 0, 0, 0);
    check("crc8:zero", value, 0);

    build(64'hF4, 8, 13);
    run_frame("crc8_flip", 64'h07, 64'h0, 64'h0, 7'd8, 8, 0, 0, 0);
    check("crc8_flip:nonzero", (value != 64'h0), 1);

    build(64'h31C3, 16, -1);
    run_frame("xmodem", 64'h1021, 64'h0, 64'h0, 7'd16, 16, 1, 0, 0);
    check("xmodem:ok_const", crc_ok, 1);

    build(64'h0376E6E7, 32, -1);
    run_frame("mpeg2", 64'h04C11DB7, 64'hFFFFFFFF, 64'h0, 7'd32, 32, 0, 0, 0);
    check("mpeg2:ok_const", crc_ok, 1);

    build(64'h0, 0, -1);
    c64 = model_run(64'h04C11DB7, 64'hFFFFFFFF, 64, 72);
    build(c64, 64, -1);
    run_frame("crc64", 64'h04C11DB7, 64'hFFFFFFFF, 64'h0, 7'd0, 64, 0, 0, 0);
    check("crc64:no_x", $isunknown(value), 0);

    build(64'hF4, 8, -1);
    set_crc8;
    do_start(0);
    send_bits(0, 20, 0);
    check("abort:pre_count", data_count, 20);
    run_frame("abort", 64'h07, 64'h0, 64'h0, 7'd8, 8, 0, 1, 0);
    tick;
    check("abort:pulse_end", abort, 0);

    set_crc8;
    do_start(0);
    send_bits(0, 5, 0);
    run_frame("startbit", 64'h07, 64'h0, 64'h0, 7'd8, 8, 0, 1, 1);

    set_crc8;
    do_start(0);
    send_bits(0, 75, 0);
    check("arst:in_crc", busy, 1);
    #2;
    rst_n = 1'b0;
    #2;
    check("arst:busy", busy, 0);
    check("arst:done", done, 0);
    check("arst:ok", crc_ok, 0);
    check("arst:err", crc_err, 0);
    check("arst:abort", abort, 0);
    check("arst:count", data_count, 0);
    check("arst:value", value, 0);
    #3;
    rst_n = 1'b1;
    tick;
    run_frame("after_rst", 64'h07, 64'h0, 64'h0, 7'd8, 8, 0, 0, 0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
